instr_loader: RTL and testbench

Debug-path program loader that fills the instruction memory before execution. It takes a byte stream from the debug UART receiver, assembles big-endian 32-bit instruction words and drives the memory's debug write port (`wr_instruction`, `inAddr`, `data_instruction`) at sequential word addresses. It stops on an end-marker word and then releases the pipeline.

---
 rtl/instr_loader.sv | 131 +++++++++++++
 tb/tb_instr_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Debug-path program loader: assembles big-endian words from a UART byte stream and
// writes them to instruction memory until an end marker. Optional: LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int unsigned DEPTH    = 32,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF,
  parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          wr_instruction,
  output logic [31:0]   wr_addr,
  output logic [31:0]   data_instruction,
  output logic          loading,
  output logic          done,
  output logic          overflow,
  output logic [CW-1:0] word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic          checksum_err
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd4;
  logic [7:0] csum;
`endif

  logic [2:0]  state;
  logic [1:0]  byte_idx;
  logic [31:0] asm_word;
  logic [31:0] next_word;
  logic        last_byte;

  assign next_word        = {asm_word[23:0], rx_data};
  assign last_byte        = (byte_idx == 2'd3);
  assign wr_instruction   = (state == WRITE);
  assign data_instruction = asm_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= '0;
      asm_word   <= '0;
      wr_addr    <= '0;
      word_count <= '0;
      loading    <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
      checksum_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RECV;
            byte_idx   <= '0;
            asm_word   <= '0;
            wr_addr    <= '0;
            word_count <= '0;
            loading    <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
            checksum_err <= 1'b0;
`endif
          end
        end
        RECV: begin
          if (rx_valid) begin
            asm_word <= next_word;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              if (next_word == END_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                state <= CHECK;
`else
                state   <= DONE;
                loading <= 1'b0;
                done    <= 1'b1;
`endif
              end else if (word_count == CW'(DEPTH)) begin
                state    <= DONE;
                overflow <= 1'b1;
                loading  <= 1'b0;
                done     <= 1'b1;
              end else begin
                state <= WRITE;
`ifdef LOADER_CHECKSUM_EN
                csum <= csum ^ next_word[31:24] ^ next_word[23:16]
                             ^ next_word[15:8] ^ next_word[7:0];
`endif
              end
            end
          end
        end
        WRITE: begin
          // byte_idx has wrapped to 0, so a byte arriving here becomes byte 0 of the next word
          state      <= RECV;
          wr_addr    <= wr_addr + 32'd1;
          word_count <= word_count + CW'(1);
          if (rx_valid) begin
            asm_word <= next_word;
            byte_idx <= byte_idx + 2'd1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_valid) begin
            checksum_err <= (rx_data != csum);
            state        <= DONE;
            loading      <= 1'b0;
            done         <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: stimulus queues expected memory writes, a negedge
// monitor pops and compares every write strobe; status outputs checked inline.
module tb_instr_loader;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          wr_instruction;
  logic [31:0]   wr_addr;
  logic [31:0]   data_instruction;
  logic          loading;
  logic          done;
  logic          overflow;
  logic [CW-1:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic          checksum_err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  instr_loader #(.DEPTH(DEPTH), .END_WORD(32'hFFFF_FFFF)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .wr_instruction   (wr_instruction),
    .wr_addr          (wr_addr),
    .data_instruction (data_instruction),
    .loading          (loading),
    .done             (done),
    .overflow         (overflow),
    .word_count       (word_count)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum_err     (checksum_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory samples on the negedge, so the monitor does too
  always @(negedge clk) begin
    if (wr_instruction === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", wr_addr, 32'hDEAD_DEAD);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", wr_addr, e[63:32]);
        chk("write_data", data_instruction, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] t;
    t = w;
    for (int unsigned i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
      if (gap) tick();
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Asynchronous reset pulse between edges
    #3 rst = 1'b1;
    #4;
    chk("rst_wr_instruction", {31'd0, wr_instruction}, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_data", data_instruction, 32'd0);
    chk("rst_loading", {31'd0, loading}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    #5 rst = 1'b0;
    tick();
    // Bytes without start are ignored
    send_word(32'h1122_3344, 1'b0);
    tick();
    chk("nostart_loading", {31'd0, loading}, 32'd0);
    chk("nostart_word_count", 32'(word_count), 32'd0);

    // Basic load with idle gaps between bytes
    do_start();
    chk("start_loading", {31'd0, loading}, 32'd1);
    expect_write(32'd0, 32'h2022_1820);
    expect_write(32'd1, 32'h8C02_0003);
    send_byte(8'h20); tick();
    send_byte(8'h22); tick();
    send_byte(8'h18); tick();
    send_byte(8'h20);
    chk("write_latency", {31'd0, wr_instruction}, 32'd1);
    tick();
    chk("write_one_cycle", {31'd0, wr_instruction}, 32'd0);
    send_word(32'h8C02_0003, 1'b1);
    send_word(32'hFFFF_FFFF, 1'b0);
`ifndef LOADER_CHECKSUM_EN
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_loading", {31'd0, loading}, 32'd0);
`else
    send_byte(8'h20 ^ 8'h22 ^ 8'h18 ^ 8'h20 ^ 8'h8C ^ 8'h02 ^ 8'h00 ^ 8'h03);
    chk("basic_done", {31'd0, done}, 32'd1);
`endif
    chk("basic_word_count", 32'(word_count), 32'd2);
    chk("basic_overflow", {31'd0, overflow}, 32'd0);
    chk("basic_pending", exp_q.size(), 32'd0);
    // rx_valid in DONE is ignored
    send_word(32'h0102_0304, 1'b0);
    tick();
    chk("done_ignores_rx", 32'(word_count), 32'd2);

    // Back-to-back bytes: byte 5 lands in the WRITE cycle
    do_start();
    chk("b2b_restart_done", {31'd0, done}, 32'd0);
    expect_write(32'd0, 32'h1122_3344);
    expect_write(32'd1, 32'h5566_7788);
    send_word(32'h1122_3344, 1'b0);
    send_word(32'h5566_7788, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_word_count", 32'(word_count), 32'd2);
    chk("b2b_pending", exp_q.size(), 32'd0);

    // Overflow: 33 words, only 32 written
    do_start();
    for (int unsigned i = 0; i < 33; i++) begin
      w = {i[7:0], 8'h5A, 8'hC3, ~i[7:0]};
      if (i < DEPTH) expect_write(i, w);
      send_word(w, 1'b0);
    end
    chk("ovf_overflow", {31'd0, overflow}, 32'd1);
    chk("ovf_done", {31'd0, done}, 32'd1);
    chk("ovf_loading", {31'd0, loading}, 32'd0);
    chk("ovf_word_count", 32'(word_count), 32'd32);
    tick();
    chk("ovf_pending", exp_q.size(), 32'd0);

    // Abort after 2 bytes, then reload
    do_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    #3 rst = 1'b1;
    #2;
    chk("abort_loading", {31'd0, loading}, 32'd0);
    chk("abort_overflow", {31'd0, overflow}, 32'd0);
    #2 rst = 1'b0;
    tick();
    do_start();
    expect_write(32'd0, 32'h1234_5678);
    send_byte(8'h12); tick();
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_word(32'hFFFF_FFFF, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
`endif
    chk("reload_done", {31'd0, done}, 32'd1);
    chk("reload_word_count", 32'(word_count), 32'd1);
    chk("reload_pending", exp_q.size(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    for (int unsigned k = 0; k < 2; k++) begin
      do_start();
      expect_write(32'd0, 32'h0102_0304);
      send_word(32'h0102_0304, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b0);
      chk("ck_wait_done", {31'd0, done}, 32'd0);
      send_byte((k == 0) ? 8'h04 : 8'h05);
      chk("ck_done", {31'd0, done}, 32'd1);
      chk("ck_err", {31'd0, checksum_err}, (k == 0) ? 32'd0 : 32'd1);
      chk("ck_pending", exp_q.size(), 32'd0);
    end
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
